dqn_transition_builder: RTL

Upstream feeder of the DQN replay memory. Pairs consecutive environment observations with the policy's chosen action to form complete transitions (s, a, r, s', done), then emits each as a one-cycle valid pulse on the replay memory's write interface. Also tracks per-episode step count, forces episode termination at a step limit, and keeps episode and transition counters for the controller.

---
 rtl/dqn_transition_builder_pkg.sv | 14 +
 rtl/dqn_transition_builder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dqn_transition_builder_pkg.sv
// Shared definitions for the DQN transition builder: default field widths
// and the FSM state encoding.
package dqn_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ACTION_WIDTH = 2;

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_WAIT_ACT = 2'd1,
        S_WAIT_OBS = 2'd2
    } state_t;

endpackage

// File: rtl/dqn_transition_builder.sv
// DQN transition builder: pairs consecutive observations with the chosen
// action and emits complete (s, a, r, s', done) tuples to replay memory.
// Also tracks episode step count, forces termination at the step limit and
// keeps episode / transition counters.
//
// state      | meaning
// -----------+------------------------------------------------
// S_EMPTY    | no held state; next observation becomes s
// S_WAIT_ACT | s held, waiting for the policy action
// S_WAIT_OBS | s and a held, next observation completes tuple
module dqn_transition_builder
    import dqn_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int ACTION_WIDTH      = DEF_ACTION_WIDTH,
    parameter int MAX_EPISODE_STEPS = 200,
    parameter int STEP_WIDTH        = 16,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_flush,
    input  logic                    i_obs_valid,
    input  logic [DATA_WIDTH-1:0]   i_state_0,
    input  logic [DATA_WIDTH-1:0]   i_state_1,
    input  logic [DATA_WIDTH-1:0]   i_reward,
    input  logic                    i_done,
    input  logic                    i_act_valid,
    input  logic [ACTION_WIDTH-1:0] i_action,
    output logic                    o_need_action,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_current_state_0,
    output logic [DATA_WIDTH-1:0]   o_current_state_1,
    output logic [ACTION_WIDTH-1:0] o_action,
    output logic [DATA_WIDTH-1:0]   o_reward,
    output logic [DATA_WIDTH-1:0]   o_next_state_0,
    output logic [DATA_WIDTH-1:0]   o_next_state_1,
    output logic                    o_done,
    output logic [STEP_WIDTH-1:0]   o_step_cnt,
    output logic [STEP_WIDTH-1:0]   o_episode_cnt,
    output logic [CNT_WIDTH-1:0]    o_trans_cnt,
    output logic                    o_protocol_err
);

    localparam logic [STEP_WIDTH:0] STEP_LIMIT = (STEP_WIDTH+1)'(MAX_EPISODE_STEPS);

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   held_s0_q;
    logic [DATA_WIDTH-1:0]   held_s1_q;
    logic [ACTION_WIDTH-1:0] held_act_q;

    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   cur_s0_q;
    logic [DATA_WIDTH-1:0]   cur_s1_q;
    logic [ACTION_WIDTH-1:0] act_q;
    logic [DATA_WIDTH-1:0]   reward_q;
    logic [DATA_WIDTH-1:0]   nxt_s0_q;
    logic [DATA_WIDTH-1:0]   nxt_s1_q;
    logic                    done_q;
    logic [STEP_WIDTH-1:0]   step_q;
    logic [STEP_WIDTH-1:0]   episode_q;
    logic [CNT_WIDTH-1:0]    trans_q;
    logic                    err_q;

    logic [STEP_WIDTH:0]     step_inc;
    logic                    eff_done;

    // Step-limit compare is done one bit wider so a limit equal to the
    // counter range still matches instead of wrapping.
    always_comb begin
        step_inc = {1'b0, step_q} + 1'b1;
        eff_done = i_done || (step_inc == STEP_LIMIT);
    end

    // Sequencing FSM plus all output/counter registers; flush wins over
    // every strobe, and protocol violations only ever set the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            held_s0_q  <= '0;
            held_s1_q  <= '0;
            held_act_q <= '0;
            valid_q    <= 1'b0;
            cur_s0_q   <= '0;
            cur_s1_q   <= '0;
            act_q      <= '0;
            reward_q   <= '0;
            nxt_s0_q   <= '0;
            nxt_s1_q   <= '0;
            done_q     <= 1'b0;
            step_q     <= '0;
            episode_q  <= '0;
            trans_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (i_flush) begin
                state_q <= S_EMPTY;
                step_q  <= '0;
            end else begin
                case (state_q)
                    S_EMPTY: begin
                        if (i_act_valid) begin
                            err_q <= 1'b1;
                        end
                        if (i_obs_valid) begin
                            held_s0_q <= i_state_0;
                            held_s1_q <= i_state_1;
                            state_q   <= S_WAIT_ACT;
                        end
                    end
                    S_WAIT_ACT: begin
                        if (i_act_valid) begin
                            // The action wins a same-cycle collision; the
                            // observation is dropped.
                            held_act_q <= i_action;
                            state_q    <= S_WAIT_OBS;
                            if (i_obs_valid) begin
                                err_q <= 1'b1;
                            end
                        end else if (i_obs_valid) begin
                            held_s0_q <= i_state_0;
                            held_s1_q <= i_state_1;
                            err_q     <= 1'b1;
                        end
                    end
                    S_WAIT_OBS: begin
                        if (i_act_valid) begin
                            err_q <= 1'b1;
                        end
                        if (i_obs_valid) begin
                            valid_q  <= 1'b1;
                            cur_s0_q <= held_s0_q;
                            cur_s1_q <= held_s1_q;
                            act_q    <= held_act_q;
                            reward_q <= i_reward;
                            nxt_s0_q <= i_state_0;
                            nxt_s1_q <= i_state_1;
                            done_q   <= eff_done;
                            trans_q  <= trans_q + 1'b1;
                            if (eff_done) begin
                                step_q  <= '0;
                                state_q <= S_EMPTY;
                                if (episode_q != '1) begin
                                    episode_q <= episode_q + 1'b1;
                                end
                            end else begin
                                // s' of this tuple is s of the next one.
                                step_q    <= step_inc[STEP_WIDTH-1:0];
                                held_s0_q <= i_state_0;
                                held_s1_q <= i_state_1;
                                state_q   <= S_WAIT_ACT;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_EMPTY;
                    end
                endcase
            end
        end
    end

    assign o_need_action     = (state_q == S_WAIT_ACT);
    assign o_valid           = valid_q;
    assign o_current_state_0 = cur_s0_q;
    assign o_current_state_1 = cur_s1_q;
    assign o_action          = act_q;
    assign o_reward          = reward_q;
    assign o_next_state_0    = nxt_s0_q;
    assign o_next_state_1    = nxt_s1_q;
    assign o_done            = done_q;
    assign o_step_cnt        = step_q;
    assign o_episode_cnt     = episode_q;
    assign o_trans_cnt       = trans_q;
    assign o_protocol_err    = err_q;

endmodule
